// File: rtl/lamp_sequencer.sv
// lamp_sequencer: plays a selected three-step lamp pattern, holding each lamp
// for a programmable dwell time, with a one-cycle all-dark gap after each
// sequence and a programmable number of repeats. Used as a stimulus source
// for the lamp-sequence alarm detector.
//
// Request semantics: start and abort are level-sampled requests with no
// separate ready. start is accepted on a rising edge where the block is in
// IDLE and abort is low; busy=0 is the equivalent of "ready". abort is honoured
// in every non-IDLE state and beats start in IDLE. reset beats both.
module lamp_sequencer #(
    parameter int DWELL_W = 8,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         pattern,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [REP_W-1:0]   repeat_n,
    output logic               lamp1,
    output logic               lamp2,
    output logic               lamp3,
    output logic               busy,
    output logic               done,
    output logic [REP_W:0]     seq_cnt,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP0 = 3'd1,
        S_STEP1 = 3'd2,
        S_STEP2 = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // Parameters latched at start; they never follow the inputs mid-run.
    logic [1:0]         r_pattern;
    logic [DWELL_W-1:0] r_dwell;
    logic [REP_W-1:0]   r_rem;
    logic [DWELL_W-1:0] r_dcnt;
    logic [REP_W:0]     r_seq_cnt;

    logic [2:0]         r_lamps;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_in_step;
    logic               w_next_is_step;
    logic               w_step_entry;
    logic [DWELL_W-1:0] w_d_eff;
    logic [1:0]         w_pat_nxt;
    logic [2:0]         w_lamps_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // One-hot lamp vector {lamp3,lamp2,lamp1} for a pattern and step index.
    function automatic logic [2:0] lamp_of(input logic [1:0] pat, input logic [1:0] stp);
        logic [2:0] v;
        v = 3'b000;
        case (pat)
            2'b00: case (stp)
                2'd0:    v = 3'b001;
                2'd1:    v = 3'b010;
                2'd2:    v = 3'b100;
                default: v = 3'b000;
            endcase
            2'b01: case (stp)
                2'd0:    v = 3'b001;
                2'd1:    v = 3'b100;
                2'd2:    v = 3'b010;
                default: v = 3'b000;
            endcase
            2'b10: case (stp)
                2'd0:    v = 3'b100;
                2'd1:    v = 3'b010;
                2'd2:    v = 3'b001;
                default: v = 3'b000;
            endcase
            default: case (stp)
                2'd0:    v = 3'b001;
                2'd1:    v = 3'b010;
                2'd2:    v = 3'b001;
                default: v = 3'b000;
            endcase
        endcase
        return v;
    endfunction

    // A dwell of zero behaves as one cycle per step.
    assign w_d_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_accept = (r_state == S_IDLE) && start && !abort;

    assign w_in_step      = (r_state == S_STEP0) || (r_state == S_STEP1) || (r_state == S_STEP2);
    assign w_next_is_step = (w_next_state == S_STEP0) || (w_next_state == S_STEP1) ||
                            (w_next_state == S_STEP2);
    assign w_step_entry   = w_next_is_step && (w_next_state != r_state);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: dwell counter expiry advances steps, abort exits.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_STEP0;
            end
            S_STEP0: begin
                if (abort)               w_next_state = S_IDLE;
                else if (r_dcnt == '0)   w_next_state = S_STEP1;
            end
            S_STEP1: begin
                if (abort)               w_next_state = S_IDLE;
                else if (r_dcnt == '0)   w_next_state = S_STEP2;
            end
            S_STEP2: begin
                if (abort)               w_next_state = S_IDLE;
                else if (r_dcnt == '0)   w_next_state = S_GAP;
            end
            S_GAP: begin
                if (abort)               w_next_state = S_IDLE;
                else if (r_rem != '0)    w_next_state = S_STEP0;
                else                     w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode for the upcoming cycle; registered below so every
    // output lines up with the state it belongs to.
    always_comb begin
        w_pat_nxt   = (r_state == S_IDLE) ? pattern : r_pattern;
        w_lamps_nxt = 3'b000;
        w_busy_nxt  = (w_next_state != S_IDLE);
        w_done_nxt  = 1'b0;
        case (w_next_state)
            S_STEP0: w_lamps_nxt = lamp_of(w_pat_nxt, 2'd0);
            S_STEP1: w_lamps_nxt = lamp_of(w_pat_nxt, 2'd1);
            S_STEP2: w_lamps_nxt = lamp_of(w_pat_nxt, 2'd2);
            S_GAP:   w_done_nxt  = (r_rem == '0);
            default: w_lamps_nxt = 3'b000;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lamps <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_lamps <= w_lamps_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Latched run parameters, dwell counter, repeat counter and sequence count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= 2'b00;
            r_dwell   <= '0;
            r_rem     <= '0;
            r_dcnt    <= '0;
            r_seq_cnt <= '0;
        end else if (w_accept) begin
            r_pattern <= pattern;
            r_dwell   <= w_d_eff;
            r_rem     <= repeat_n;
            r_dcnt    <= w_d_eff - DWELL_W'(1);
            r_seq_cnt <= '0;
        end else begin
            if (w_next_state == S_IDLE) begin
                r_dcnt <= '0;
            end else if (w_step_entry) begin
                r_dcnt <= r_dwell - DWELL_W'(1);
            end else if (w_in_step) begin
                r_dcnt <= r_dcnt - DWELL_W'(1);
            end

            if ((w_next_state == S_GAP) && (r_state != S_GAP)) begin
                r_seq_cnt <= r_seq_cnt + (REP_W+1)'(1);
            end

            if ((r_state == S_GAP) && (w_next_state == S_STEP0)) begin
                r_rem <= r_rem - REP_W'(1);
            end
        end
    end

    assign lamp1     = r_lamps[0];
    assign lamp2     = r_lamps[1];
    assign lamp3     = r_lamps[2];
    assign busy      = r_busy;
    assign done      = r_done;
    assign seq_cnt   = r_seq_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer. Inputs change 1 time unit after a rising
// edge; outputs are checked at the same point, i.e. "cycle c" is the cycle
// following the c-th edge after the start request was applied.
module tb_lamp_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] pattern;
    logic [7:0] dwell;
    logic [3:0] repeat_n;
    logic       lamp1;
    logic       lamp2;
    logic       lamp3;
    logic       busy;
    logic       done;
    logic [4:0] seq_cnt;
    logic [2:0] dbg_state;

    int n_checks;
    int n_fail;

    lamp_sequencer #(.DWELL_W(8), .REP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .dwell     (dwell),
        .repeat_n  (repeat_n),
        .lamp1     (lamp1),
        .lamp2     (lamp2),
        .lamp3     (lamp3),
        .busy      (busy),
        .done      (done),
        .seq_cnt   (seq_cnt),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lamps given as {lamp3,lamp2,lamp1}.
    task automatic chk_out(input string tag, input logic [2:0] l, input logic b,
                           input logic d, input logic [4:0] s);
        chk({tag, ".lamps"}, {29'b0, lamp3, lamp2, lamp1}, {29'b0, l});
        chk({tag, ".busy"},  {31'b0, busy},  {31'b0, b});
        chk({tag, ".done"},  {31'b0, done},  {31'b0, d});
        chk({tag, ".seq"},   {27'b0, seq_cnt}, {27'b0, s});
    endtask

    initial begin
        logic [2:0] el;
        int         pos;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        pattern  = 2'b00;
        dwell    = 8'd1;
        repeat_n = 4'd0;
        step();
        step();
        chk_out("rst", 3'b000, 1'b0, 1'b0, 5'd0);
        chk("rst.state", {29'b0, dbg_state}, 32'd0);
        reset = 1'b0;
        step();

        // Pattern 00, dwell 2, single sequence
        pattern = 2'b00; dwell = 8'd2; repeat_n = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            el = (c <= 2) ? 3'b001 : (c <= 4) ? 3'b010 : (c <= 6) ? 3'b100 : 3'b000;
            chk_out($sformatf("p00.c%0d", c), el, (c <= 7), (c == 7), (c >= 7) ? 5'd1 : 5'd0);
            step();
        end

        // Pattern 01, dwell 0 (acts as 1), three sequences
        pattern = 2'b01; dwell = 8'd0; repeat_n = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            pos = (c - 1) % 4;
            el  = (c == 13) ? 3'b000 : (pos == 0) ? 3'b001 : (pos == 1) ? 3'b100 :
                  (pos == 2) ? 3'b010 : 3'b000;
            chk_out($sformatf("p01.c%0d", c), el, (c <= 12), (c == 12), 5'(c / 4));
            step();
        end

        // Pattern 11, dwell 3; inputs disturbed and start held during the run
        pattern = 2'b11; dwell = 8'd3; repeat_n = 4'd0; start = 1'b1;
        step();
        for (int c = 1; c <= 10; c++) begin
            el = (c <= 3) ? 3'b001 : (c <= 6) ? 3'b010 : (c <= 9) ? 3'b001 : 3'b000;
            chk_out($sformatf("p11.c%0d", c), el, 1'b1, (c == 10), (c == 10) ? 5'd1 : 5'd0);
            if (c == 2) begin
                pattern = 2'b00; dwell = 8'd7; repeat_n = 4'd5;
            end
            step();
        end
        start = 1'b0;
        chk_out("p11.c11", 3'b000, 1'b0, 1'b0, 5'd1);
        step();
        chk_out("p11.c12", 3'b000, 1'b0, 1'b0, 5'd1);

        // Pattern 10, dwell 4, abort in the 2nd cycle of STEP1
        pattern = 2'b10; dwell = 8'd4; repeat_n = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk_out($sformatf("abt.c%0d", c), (c <= 4) ? 3'b100 : 3'b010, 1'b1, 1'b0, 5'd0);
            if (c < 6) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_out("abt.c7", 3'b000, 1'b0, 1'b0, 5'd0);
        chk("abt.state", {29'b0, dbg_state}, 32'd0);
        for (int c = 8; c <= 10; c++) begin
            step();
            chk_out($sformatf("abt.c%0d", c), 3'b000, 1'b0, 1'b0, 5'd0);
        end

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk_out("abtstart", 3'b000, 1'b0, 1'b0, 5'd0);
        chk("abtstart.state", {29'b0, dbg_state}, 32'd0);
        step();

        // Reset mid-sequence (STEP1 of the second sequence)
        pattern = 2'b00; dwell = 8'd1; repeat_n = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            el = (c == 1 || c == 5) ? 3'b001 : (c == 2 || c == 6) ? 3'b010 :
                 (c == 3) ? 3'b100 : 3'b000;
            chk_out($sformatf("rmid.c%0d", c), el, 1'b1, 1'b0, (c >= 4) ? 5'd1 : 5'd0);
            if (c < 6) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_out("rmid.c7", 3'b000, 1'b0, 1'b0, 5'd0);
        chk("rmid.state", {29'b0, dbg_state}, 32'd0);
        repeat_n = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk_out("rmid.c8", 3'b001, 1'b1, 1'b0, 5'd0);
        step(); step(); step();
        chk_out("rmid.c11", 3'b000, 1'b1, 1'b1, 5'd1);
        step();

        // Back-to-back runs with start held high
        pattern = 2'b00; dwell = 8'd1; repeat_n = 4'd0; start = 1'b1;
        step();
        for (int c = 1; c <= 15; c++) begin
            pos = (c - 1) % 5;
            if (c == 15) begin
                chk_out("b2b.c15", 3'b000, 1'b0, 1'b0, 5'd1);
            end else begin
                el = (pos == 0) ? 3'b001 : (pos == 1) ? 3'b010 : (pos == 2) ? 3'b100 : 3'b000;
                chk_out($sformatf("b2b.c%0d", c), el, (pos <= 3), (pos == 3),
                        (pos >= 3) ? 5'd1 : 5'd0);
            end
            if (c == 14) start = 1'b0;
            step();
        end
        chk_out("b2b.end", 3'b000, 1'b0, 1'b0, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lamp_sequencer.md
Name: lamp_sequencer

Overview:
Stimulus generator that drives the three lamp lines consumed by the lamp-sequence alarm detector. On a start request it plays a selected lamp pattern. Each lamp is held for a programmable dwell time, and the pattern is repeated a programmable number of times. It gives the lab board, and the bench, a deterministic source of both valid (alarm-triggering) and broken sequences.

Parameters:
DWELL_W, 8, width of dwell-time input (cycles per lamp step)
REP_W, 4, width of repeat input; number of sequences played = repeat_n+1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin; accepted only in IDLE
abort  input  1  stop immediately; no done pulse
pattern  input  2  lamp order: 00=1-2-3, 01=1-3-2, 10=3-2-1, 11=1-2-1
dwell  input  DWELL_W  cycles each lamp stays on; 0 treated as 1
repeat_n  input  REP_W  extra repetitions; sequences played = repeat_n+1
lamp1  output  1  lamp 1 drive
lamp2  output  1  lamp 2 drive
lamp3  output  1  lamp 3 drive
busy  output  1  high from first lamp cycle through final GAP cycle
done  output  1  one-cycle pulse on the final GAP cycle of a normal completion
seq_cnt  output  REP_W+1  sequences completed since last accepted start

Behaviour:
- Reset: state=IDLE. lamp1..3=0, busy=0, done=0, seq_cnt=0, internal counters=0. Reset has priority over abort and start, including mid-sequence.
- All outputs are registered. Lamps are one-hot or all zero; two lamps are never high at once.
- States: IDLE, STEP0, STEP1, STEP2, GAP.
- IDLE: when start=1 and abort=0 at edge k:
  - latch pattern, D=max(dwell,1), and rem=repeat_n;
  - clear seq_cnt;
  - go to STEP0.
  - The first lamp is visible from cycle k+1.
- STEPn (n=0..2):
  - drive the lamp pattern[n], where 00→(1,2,3), 01→(1,3,2), 10→(3,2,1), 11→(1,2,1);
  - stay exactly D cycles, using a dwell counter reloaded on every step entry;
  - then advance STEP0→STEP1→STEP2→GAP.
- GAP lasts exactly 1 cycle with all lamps 0, so the detector returns to idle between sequences.
  - seq_cnt increments by 1 on GAP entry.
  - If rem≠0: rem decrements and the next state is STEP0.
  - Else: done=1 during this GAP cycle, and the next state is IDLE.
- busy = 1 in the STEP0..GAP states and 0 in IDLE.
- start while busy is ignored. Latched parameters never change mid-run, even if the inputs change.
- Earliest restart: start sampled in the cycle after the final GAP, when the block is in IDLE.
- abort=1 in any non-IDLE state: at the next edge go to IDLE, lamps=0, busy=0, no done pulse, seq_cnt holds its value.
- abort and start together in IDLE: abort wins and the block stays in IDLE.
- One sequence lasts 3·D+1 cycles. A full run lasts (repeat_n+1)·(3·D+1) cycles.
- seq_cnt cannot overflow: its maximum is 2^REP_W, which fits in REP_W+1 bits.

Test Plan:
- Reset mid-sequence (during STEP1) → next cycle all lamps 0, busy=0, seq_cnt=0, done=0; the block is in IDLE and accepts start.
- pattern=00, dwell=2, repeat_n=0, start at cycle 0 → lamp1 high in cycles 1–2, lamp2 in 3–4, lamp3 in 5–6, all off in cycle 7 with done=1 and seq_cnt=1; busy=1 in cycles 1–7 and 0 in cycle 8. A connected detector asserts alarm after lamp3.
- pattern=01, dwell=0, repeat_n=2 → order 1,3,2 with 1 cycle each plus a 1-cycle gap, repeated 3 times (12 cycles). seq_cnt steps 1,2,3; a single done pulse in cycle 12; the detector never alarms.
- pattern=11, dwell=3: re-pulse start and change dwell/pattern during the run → lamps follow 1,2,1 at 3 cycles each, unaffected; no restart occurs.
- abort in the 2nd cycle of STEP1 (pattern=10, dwell=4) → lamps 0 and busy 0 from the next cycle; done is never asserted; seq_cnt stays 0.
- Back-to-back runs: start held high continuously with dwell=1, repeat_n=0 → runs occupy cycles 1–4, then IDLE in cycle 5 (start accepted), then 6–9, and so on; the lamps are never high in the IDLE cycle.
